// File: rtl/shftreg_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter: FSM state
// encoding, minimum word width and the even-parity helper.
package shftreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

  localparam int N_MIN = 2;

  // Even parity of a word of up to 64 bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/shftreg_piso_bitcnt_n.sv
// Bit-position counter for the PISO frame: synchronous clear (priority over
// enable), count enable, and a flag that is high while the count equals TC.
module bitcnt_n #(
  parameter int CNT_W = 4,
  parameter int TC    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(TC));

endmodule

// File: rtl/shftreg_piso.sv
// N-bit parallel-in/serial-out shifter, MSB first, with a ready/valid load
// handshake and zero-gap back-to-back framing. Define SHFT_PARITY_EN to append
// an even-parity bit to every frame (frame length N+1 instead of N).
module shftreg_piso
  import shftreg_pkg::*;
#(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] DIN,
  input  logic         LD_VALID,
  output logic         LD_READY,
  output logic         SOUT,
  output logic         SVALID,
  output logic         SLAST,
  output logic         BUSY
);

  generate
    if (N < N_MIN) begin : g_bad_width
      $error("shftreg_piso: N must be at least %0d", N_MIN);
    end
  endgenerate

  state_e       state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic         cnt_clr, cnt_en, cnt_tc;
  logic         accept, load;
`ifdef SHFT_PARITY_EN
  logic         par_q, par_d;
`endif

  bitcnt_n #(
    .CNT_W (CNT_W),
    .TC    (N - 1)
  ) u_bitcnt (
    .clk (CLK),
    .rst (RESET),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // Serial outputs decode only registered state, so DIN/LD_VALID never reach them combinationally.
  always_comb begin
    SVALID = (state_q != ST_IDLE);
    BUSY   = SVALID;
`ifdef SHFT_PARITY_EN
    SLAST  = (state_q == ST_PAR);
    SOUT   = 1'b0;
    if (state_q == ST_SHIFT) begin
      SOUT = sreg_q[N-1];
    end else if (state_q == ST_PAR) begin
      SOUT = par_q;
    end
`else
    SLAST  = (state_q == ST_SHIFT) && cnt_tc;
    SOUT   = (state_q == ST_SHIFT) && sreg_q[N-1];
`endif
    LD_READY = (state_q == ST_IDLE) || (SLAST && SVALID);
  end

  assign accept = LD_VALID && LD_READY;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    load    = 1'b0;
`ifdef SHFT_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        load = accept;
      end

      ST_SHIFT: begin
        sreg_d = {sreg_q[N-2:0], 1'b0};
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
`ifdef SHFT_PARITY_EN
          state_d = ST_PAR;
`else
          load    = accept;
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end

`ifdef SHFT_PARITY_EN
      ST_PAR: begin
        load    = accept;
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A load, from idle or on a frame's final cycle, starts a fresh frame.
    if (load) begin
      state_d = ST_SHIFT;
      sreg_d  = DIN;
      cnt_clr = 1'b1;
`ifdef SHFT_PARITY_EN
      par_d   = even_parity(64'(DIN));
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      // NOTE: the shift register is reset too: a reset mid-frame must not leave stale bits behind for the next frame.
      sreg_q  <= '0;
`ifdef SHFT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
`ifdef SHFT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_shftreg_piso.sv
// Directed self-checking bench for shftreg_piso (N=8); follows SHFT_PARITY_EN
// so the same vectors check both the plain and the parity-framed build.
module tb_shftreg_piso;

`ifdef SHFT_PARITY_EN
  localparam int FL     = 9;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FL     = 8;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DIN;
  logic       LD_VALID;
  logic       LD_READY, SOUT, SVALID, SLAST, BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sipo_q;
  logic [7:0] words [256];

  shftreg_piso #(.N(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DIN      (DIN),
    .LD_VALID (LD_VALID),
    .LD_READY (LD_READY),
    .SOUT     (SOUT),
    .SVALID   (SVALID),
    .SLAST    (SLAST),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Downstream SIPO; the parity bit is not part of the data word.
  always @(posedge CLK) begin
    if (SVALID && !(PAR_EN && SLAST)) sipo_q <= {sipo_q[6:0], SOUT};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected serial bit i of a frame carrying word w.
  function automatic logic fbit(input logic [7:0] w, input int i);
    if (i < 8) return w[7-i];
    return ^w;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_svalid"}, 8'(SVALID), 8'd0);
    chk({tag, "_sout"},   8'(SOUT),   8'd0);
    chk({tag, "_slast"},  8'(SLAST),  8'd0);
    chk({tag, "_busy"},   8'(BUSY),   8'd0);
    chk({tag, "_ready"},  8'(LD_READY), 8'd1);
  endtask

  // Checks one frame of word w starting in its first bit cycle; ends one cycle after its last bit.
  task automatic run_frame(input string tag, input logic [7:0] w, input logic junk,
                           input logic next_v, input logic [7:0] next_w);
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("%s_sout%0d", tag, i),   8'(SOUT),     8'(fbit(w, i)));
      chk($sformatf("%s_svalid%0d", tag, i), 8'(SVALID),   8'd1);
      chk($sformatf("%s_busy%0d", tag, i),   8'(BUSY),     8'd1);
      chk($sformatf("%s_slast%0d", tag, i),  8'(SLAST),    8'(i == FL - 1));
      chk($sformatf("%s_ready%0d", tag, i),  8'(LD_READY), 8'(i == FL - 1));
      if (i == FL - 1) begin
        DIN      = next_w;
        LD_VALID = next_v;
      end else if (junk) begin
        DIN      = 8'($urandom);
        LD_VALID = logic'(i % 2);
      end
      tick();
    end
  endtask

  initial begin
    RESET    = 1'b1;
    DIN      = 8'h00;
    LD_VALID = 1'b0;
    #2;
    check_idle("reset");
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check_idle("post_reset");

    // Single A5 word from idle.
    DIN = 8'hA5; LD_VALID = 1'b1;
    tick();
    LD_VALID = 1'b0; DIN = 8'h00;
    run_frame("t1", 8'hA5, 1'b0, 1'b0, 8'h00);
    check_idle("t1_end");

    // Back-to-back FF then 00 with LD_VALID held high.
    DIN = 8'hFF; LD_VALID = 1'b1;
    tick();
    DIN = 8'h00;
    run_frame("t2a", 8'hFF, 1'b0, 1'b1, 8'h00);
    run_frame("t2b", 8'h00, 1'b0, 1'b0, 8'h00);
    check_idle("t2_end");

    // Loopback of 256 random words into the SIPO, continuous stream.
    for (int j = 0; j < 256; j++) words[j] = 8'($urandom);
    DIN = words[0]; LD_VALID = 1'b1;
    tick();
    for (int j = 0; j < 256; j++) begin
      for (int i = 0; i < FL; i++) begin
        chk($sformatf("t3_sout_w%0d_b%0d", j, i), 8'(SOUT), 8'(fbit(words[j], i)));
        if (i == FL - 1) begin
          chk($sformatf("t3_slast_w%0d", j), 8'(SLAST), 8'd1);
          if (j < 255) DIN = words[j+1];
          else LD_VALID = 1'b0;
        end
        tick();
      end
      chk($sformatf("t3_sipo_w%0d", j), sipo_q, words[j]);
    end
    check_idle("t3_end");

    // Asynchronous reset during bit 4 of 3C, then a clean 81 frame.
    DIN = 8'h3C; LD_VALID = 1'b1;
    tick();
    LD_VALID = 1'b0;
    repeat (4) tick();
    chk("t4_pre_sout",   8'(SOUT),   8'd1);
    chk("t4_pre_svalid", 8'(SVALID), 8'd1);
    #2;
    RESET = 1'b1;
    #1;
    check_idle("t4_rst");
    #2;
    RESET = 1'b0;
    DIN = 8'h81; LD_VALID = 1'b1;
    tick();
    LD_VALID = 1'b0;
    run_frame("t4", 8'h81, 1'b0, 1'b0, 8'h00);
    check_idle("t4_end");

    // LD_VALID toggling and DIN changing while busy; reload only on the last cycle.
    DIN = 8'h5A; LD_VALID = 1'b1;
    tick();
    run_frame("t5a", 8'h5A, 1'b1, 1'b1, 8'hC3);
    run_frame("t5b", 8'hC3, 1'b1, 1'b0, 8'h00);
    check_idle("t5_end");

    // 07 followed by a reload on its final (parity when enabled) cycle.
    DIN = 8'h07; LD_VALID = 1'b1;
    tick();
    run_frame("t6a", 8'h07, 1'b0, 1'b1, 8'hE1);
    run_frame("t6b", 8'hE1, 1'b0, 1'b0, 8'h00);
    check_idle("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
